// File: rtl/pulse_sequencer_nch.sv
// Multi-channel pulse sequencer: one period counter, NCH delay/width windows,
// free-run / one-shot / sync-retrigger modes with period-boundary config updates.
module pulse_sequencer_nch #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32,
  parameter int unsigned PCW = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              trigger,
  input  logic              load,
  input  logic [CW-1:0]     period_div,
  input  logic [NCH*CW-1:0] delay_div,
  input  logic [NCH*CW-1:0] pw_div,
  output logic [NCH-1:0]    pulse_out,
  output logic              period_start,
  output logic              busy,
  output logic [PCW-1:0]    period_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     sh_per_q, sh_per_d, act_per_q, act_per_d;
  logic [NCH*CW-1:0] sh_dly_q, sh_dly_d, sh_pw_q, sh_pw_d;
  logic [NCH*CW-1:0] act_dly_q, act_dly_d, act_pw_q, act_pw_d;
  logic              trig_prev_q, trig_prev_d;
  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic [NCH-1:0]    pulse_q, pulse_d;
  logic              start_q, start_d, busy_q, busy_d;

  logic trig_edge, free_mode, sync_mode, wrap, retrig, boundary;

  assign trig_edge = trigger & ~trig_prev_q;
  assign free_mode = (mode == 2'b00) || (mode == 2'b11);
  assign sync_mode = (mode == 2'b10);
  assign wrap      = (state_q == StRun) &&
                     (({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) >= {1'b0, act_per_q});
  assign retrig    = (state_q == StRun) && sync_mode && trig_edge;
  assign boundary  = wrap || retrig;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_per_q    <= '0;
      sh_dly_q    <= '0;
      sh_pw_q     <= '0;
      act_per_q   <= '0;
      act_dly_q   <= '0;
      act_pw_q    <= '0;
      trig_prev_q <= 1'b0;
      pcnt_q      <= '0;
      pulse_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_per_q    <= sh_per_d;
      sh_dly_q    <= sh_dly_d;
      sh_pw_q     <= sh_pw_d;
      act_per_q   <= act_per_d;
      act_dly_q   <= act_dly_d;
      act_pw_q    <= act_pw_d;
      trig_prev_q <= trig_prev_d;
      pcnt_q      <= pcnt_d;
      pulse_q     <= pulse_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    trig_prev_d = trigger;
    sh_per_d    = sh_per_q;
    sh_dly_d    = sh_dly_q;
    sh_pw_d     = sh_pw_q;
    if (load) begin
      sh_per_d = period_div;
      sh_dly_d = delay_div;
      sh_pw_d  = pw_div;
    end
    // Active config follows the old shadow, so a load on a wrap lands one period later.
    act_per_d = act_per_q;
    act_dly_d = act_dly_q;
    act_pw_d  = act_pw_q;
    if ((state_q != StRun) || boundary) begin
      act_per_d = sh_per_q;
      act_dly_d = sh_dly_q;
      act_pw_d  = sh_pw_q;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          if (!free_mode) begin
            state_d = StArmed;
          end else if (act_per_d != '0) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
      end
      StArmed: begin
        if (!enable || free_mode) begin
          state_d = StIdle;
        end else if (trig_edge && (act_per_d != '0)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (boundary) begin
          cnt_d  = '0;
          pcnt_d = pcnt_q + PCW'(1);
          if (free_mode) begin
            if (!enable || (act_per_d == '0)) state_d = StIdle;
          end else if (!retrig || (act_per_d == '0)) begin
            state_d = enable ? StArmed : StIdle;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == StRun);
    start_d = busy_d && (cnt_d == '0);
  end

  // Window end is formed at CW+1 bits so delay+width never wraps.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] dly, pw;
    logic [CW:0]   win_end;
    assign dly        = act_dly_d[i*CW +: CW];
    assign pw         = act_pw_d[i*CW +: CW];
    assign win_end    = {1'b0, dly} + {1'b0, pw};
    assign pulse_d[i] = busy_d && (cnt_d >= dly) && ({1'b0, cnt_d} < win_end);
  end

  assign pulse_out    = pulse_q;
  assign period_start = start_q;
  assign busy         = busy_q;
  assign period_count = pcnt_q;

endmodule

// File: tb/tb_pulse_sequencer_nch.sv
// Self-checking bench for pulse_sequencer_nch: window table, directed mode sequences,
// and randomized traffic against a behavioural model.
module tb_pulse_sequencer_nch;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PCW = 16;

  logic              clk_in = 1'b0;
  logic              reset, enable, trigger, load;
  logic [1:0]        mode;
  logic [CW-1:0]     period_div;
  logic [NCH*CW-1:0] delay_div, pw_div;
  logic [NCH-1:0]    pulse_out;
  logic              period_start, busy;
  logic [PCW-1:0]    period_count;

  always #5 clk_in = ~clk_in;

  pulse_sequencer_nch #(.NCH(NCH), .CW(CW), .PCW(PCW)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .trigger      (trigger),
    .load         (load),
    .period_div   (period_div),
    .delay_div    (delay_div),
    .pw_div       (pw_div),
    .pulse_out    (pulse_out),
    .period_start (period_start),
    .busy         (busy),
    .period_count (period_count)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [CW-1:0]     per;
    logic [NCH*CW-1:0] dly;
    logic [NCH*CW-1:0] pw;
    logic [NCH*16-1:0] mask;  // per channel: bit k set when high at cnt k
  } vec_t;
  vec_t tbl [4];

  task automatic set_cfg(input logic [CW-1:0] per, input logic [NCH*CW-1:0] d,
                         input logic [NCH*CW-1:0] p);
    period_div = per;
    delay_div  = d;
    pw_div     = p;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    @(negedge clk_in);
    reset  = 1'b0;
  endtask

  task automatic load_and_go();
    load = 1'b1;
    @(negedge clk_in);
    load   = 1'b0;
    enable = 1'b1;
  endtask

  // Behavioural model: in-run flag, armed flag, position within period.
  bit              m_run, m_armed, m_prev;
  longint unsigned m_pos, m_cnt;
  longint unsigned m_sh_per, m_act_per;
  longint unsigned m_sh_dly [NCH], m_sh_pw [NCH], m_act_dly [NCH], m_act_pw [NCH];

  task automatic model_step(input bit rst, input bit en, input logic [1:0] md, input bit trg,
                            input bit ld, input logic [CW-1:0] per,
                            input logic [NCH*CW-1:0] d, input logic [NCH*CW-1:0] p);
    longint unsigned o_per;
    longint unsigned o_dly [NCH];
    longint unsigned o_pw [NCH];
    bit edge_seen, done, re;
    int eff;
    if (rst) begin
      m_run = 0; m_armed = 0; m_prev = 0; m_pos = 0; m_cnt = 0;
      m_sh_per = 0; m_act_per = 0;
      for (int i = 0; i < NCH; i++) begin
        m_sh_dly[i] = 0; m_sh_pw[i] = 0; m_act_dly[i] = 0; m_act_pw[i] = 0;
      end
      return;
    end
    edge_seen = trg && !m_prev;
    m_prev    = trg;
    eff       = (md == 2'd3) ? 0 : int'(md);
    o_per     = m_sh_per;
    o_dly     = m_sh_dly;
    o_pw      = m_sh_pw;
    if (ld) begin
      m_sh_per = per;
      for (int i = 0; i < NCH; i++) begin
        m_sh_dly[i] = d[i*CW +: CW];
        m_sh_pw[i]  = p[i*CW +: CW];
      end
    end
    if (!m_run) begin
      m_act_per = o_per; m_act_dly = o_dly; m_act_pw = o_pw;
      if (!m_armed) begin
        if (en) begin
          if (eff != 0) m_armed = 1;
          else if (m_act_per != 0) begin m_run = 1; m_pos = 0; end
        end
      end else begin
        if (!en || eff == 0) m_armed = 0;
        else if (edge_seen && m_act_per != 0) begin m_armed = 0; m_run = 1; m_pos = 0; end
      end
    end else begin
      done = (m_pos + 1 >= m_act_per);
      re   = (eff == 2) && edge_seen;
      if (done || re) begin
        m_cnt++;
        m_pos = 0;
        m_act_per = o_per; m_act_dly = o_dly; m_act_pw = o_pw;
        if (eff == 0) begin
          if (!en || m_act_per == 0) m_run = 0;
        end else if (!re || m_act_per == 0) begin
          m_run = 0; m_armed = en;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [21:0] model_out();
    logic [NCH-1:0] pl;
    logic [PCW-1:0] pc;
    for (int i = 0; i < NCH; i++)
      pl[i] = m_run && (m_pos >= m_act_dly[i]) && (m_pos < m_act_dly[i] + m_act_pw[i]);
    pc = PCW'(m_cnt % 65536);
    return {pl, m_run && (m_pos == 0), m_run, pc};
  endfunction

  initial begin
    int busy_n;
    int ps_idx [$];
    int exp_sh [7] = '{0, 8, 12, 16, 20, 26, 32};
    logic [NCH-1:0] e;
    bit r_rst, r_en, r_trg, r_ld;
    logic [1:0] r_md;

    reset = 1'b1; enable = 1'b0; mode = 2'b00; trigger = 1'b0; load = 1'b0;
    set_cfg('0, '0, '0);
    @(negedge clk_in);
    chk("reset_state", {pulse_out, period_start, busy, period_count}, '0);
    reset = 1'b0;

    tbl[0] = '{per: 32'd8, dly: {32'd6, 32'd4, 32'd2, 32'd0}, pw: {4{32'd2}},
               mask: {16'h00C0, 16'h0030, 16'h000C, 16'h0003}};
    tbl[1] = '{per: 32'd10, dly: {32'd0, 32'd10, 32'd0, 32'd8},
               pw: {32'd20, 32'd3, 32'd0, 32'd5},
               mask: {16'h03FF, 16'h0000, 16'h0000, 16'h0300}};
    tbl[2] = '{per: 32'd6, dly: {32'd5, 32'd0, 32'd3, 32'd1}, pw: {32'd1, 32'd6, 32'd3, 32'd1},
               mask: {16'h0020, 16'h003F, 16'h0038, 16'h0002}};
    tbl[3] = '{per: 32'd4, dly: {32'd0, 32'd3, 32'hFFFF_FFFF, 32'd2},
               pw: {32'd4, 32'd1, 32'd1, 32'hFFFF_FFFF},
               mask: {16'h000F, 16'h0008, 16'h0000, 16'h000C}};

    // Free-run window table.
    for (int r = 0; r < 4; r++) begin
      int per;
      per  = int'(tbl[r].per);
      mode = 2'b00;
      do_reset();
      set_cfg(tbl[r].per, tbl[r].dly, tbl[r].pw);
      load_and_go();
      for (int c = 0; c < 3 * per; c++) begin
        @(negedge clk_in);
        for (int ch = 0; ch < NCH; ch++) e[ch] = tbl[r].mask[ch*16 + (c % per)];
        chk("window", pulse_out, e);
        chk("period_start", period_start, (c % per) == 0);
        chk("busy_run", busy, 1'b1);
      end
      @(negedge clk_in);
      chk("period_count_3", period_count, 3);
      enable = 1'b0;
      repeat (per - 1) @(negedge clk_in);
      chk("drain_busy", busy, 1'b1);
      @(negedge clk_in);
      chk("stop_idle", {busy, period_start, pulse_out}, '0);
    end

    // One-shot.
    mode = 2'b01;
    do_reset();
    set_cfg(32'd5, '0, {4{32'd5}});
    load_and_go();
    repeat (3) @(negedge clk_in);
    chk("os_armed_idle", {busy, pulse_out}, '0);
    for (int shot = 0; shot < 2; shot++) begin
      trigger = 1'b1;
      busy_n  = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk_in);
        if (k == 1) chk("os_latency", {busy, period_start}, 2'b11);
        if (busy) busy_n++;
        trigger = (shot == 0) && (k == 3);
      end
      chk("os_busy_len", busy_n, 5);
      chk("os_count", period_count, shot + 1);
      chk("os_rearmed", {busy, pulse_out}, '0);
    end

    // Sync-retrigger.
    mode = 2'b10;
    do_reset();
    set_cfg(32'd100, '0, {4{32'd100}});
    load_and_go();
    repeat (3) @(negedge clk_in);
    ps_idx.delete();
    for (int c = 0; c < 260; c++) begin
      trigger = (c % 40 == 0) && (c < 160);
      @(negedge clk_in);
      if (period_start) ps_idx.push_back(c + 1);
    end
    chk("sync_starts", ps_idx.size(), 4);
    for (int i = 0; i < ps_idx.size() && i < 4; i++) chk("sync_start_at", ps_idx[i], 1 + 40 * i);
    chk("sync_count", period_count, 4);
    chk("sync_armed_low", {busy, pulse_out}, '0);

    // Shadow config: mid-period load, then a load coincident with a wrap.
    mode = 2'b00;
    do_reset();
    set_cfg(32'd8, '0, '0);
    load_and_go();
    ps_idx.delete();
    for (int c = 0; c < 35; c++) begin
      @(negedge clk_in);
      if (period_start) ps_idx.push_back(c);
      load = (c == 3) || (c == 15);
      if (c == 3) period_div = 32'd4;
      if (c == 15) period_div = 32'd6;
    end
    load = 1'b0;
    chk("shadow_starts", ps_idx.size(), 7);
    for (int i = 0; i < ps_idx.size() && i < 7; i++) chk("shadow_start_at", ps_idx[i], exp_sh[i]);

    // Reset mid-run.
    do_reset();
    set_cfg(32'd8, '0, {4{32'd8}});
    load_and_go();
    repeat (14) @(negedge clk_in);
    chk("pre_reset_pulses", pulse_out, 4'hF);
    reset = 1'b1;
    @(negedge clk_in);
    chk("mid_reset", {pulse_out, period_start, busy, period_count}, '0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      chk("post_reset_idle", {busy, pulse_out}, '0);
    end
    load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    @(negedge clk_in);
    chk("reload_runs", {busy, period_start, pulse_out}, {2'b11, 4'hF});

    // Randomized traffic against the model.
    r_en = 1; r_md = 2'b00;
    for (int n = 0; n < 4000; n++) begin
      r_rst = (n == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) r_en = ~r_en;
      if ($urandom_range(0, 149) == 0) r_md = 2'($urandom_range(0, 3));
      r_trg = ($urandom_range(0, 5) == 0);
      r_ld  = ($urandom_range(0, 9) == 0);
      reset = r_rst; enable = r_en; mode = r_md; trigger = r_trg; load = r_ld;
      period_div = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      for (int i = 0; i < NCH; i++) begin
        delay_div[i*CW +: CW] = 32'($urandom_range(0, 14));
        pw_div[i*CW +: CW]    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                             : 32'($urandom_range(0, 14));
      end
      @(posedge clk_in);
      model_step(r_rst, r_en, r_md, r_trg, r_ld, period_div, delay_div, pw_div);
      @(negedge clk_in);
      chk("random", {pulse_out, period_start, busy, period_count}, model_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer_nch.md
Name: pulse_sequencer_nch

Overview:
- Parametrised successor to the fixed two-channel fast/slow pulse generators in the photon-counter design.
- One period counter drives NCH output channels, each with its own programmable delay and width.
- Three operating modes: free-run, one-shot on trigger, and sync-retrigger.
- Configuration is double-buffered and takes effect only at period boundaries, so outputs never glitch. Sits between the host wire registers and the pulse/gate output pins.

Parameters:
- NCH, 4, number of output channels.
- CW, 32, width of the period, delay and width counters.
- PCW, 16, width of the completed-period counter.

Ports:
- clk_in  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request, level.
- mode  in  2  00 free-run, 01 one-shot, 10 sync-retrigger, 11 treated as 00.
- trigger  in  1  sync/trigger input, already synchronous to clk_in.
- load  in  1  one-cycle strobe: capture all config inputs into shadow registers.
- period_div  in  CW  period length in clk_in cycles.
- delay_div  in  NCH*CW  per-channel delay; channel i occupies bits [i*CW +: CW].
- pw_div  in  NCH*CW  per-channel width; same packing as delay_div.
- pulse_out  out  NCH  registered channel outputs.
- period_start  out  1  high for the cycle in which the counter is 0 in RUN.
- busy  out  1  high in RUN.
- period_count  out  PCW  number of completed periods, wraps at 2^PCW.

Behaviour:
- Reset:
  - State goes to IDLE; counter, shadow and active config registers, pulse_out, period_start, busy and period_count all clear to 0 on the next clk_in edge.
  - Reset has priority over all other inputs, including mid-period.
- Config path:
  - A load strobe copies the inputs into the shadow registers.
  - Shadow is copied into the active registers when in IDLE/ARMED, or on the cycle the counter wraps from period-1 to 0.
  - A load and a wrap in the same cycle: the new value is active starting from the next period, not the current one.
- States IDLE, ARMED, RUN. Transitions by mode:
  - Free-run, IDLE: enable=1 → RUN with cnt=0 on the next cycle.
  - Free-run, RUN: cnt wraps forever.
  - Free-run, enable=0: the current period completes, then IDLE.
  - One-shot, IDLE: enable=1 → ARMED.
  - One-shot, ARMED: trigger rising edge (trigger=1 with previous sample 0) → RUN with cnt=0 on the next cycle.
  - One-shot, end of period: go to ARMED if enable=1, else IDLE.
  - One-shot, edges during RUN are ignored.
  - Sync-retrigger: same as one-shot, except a trigger edge during RUN forces cnt=0 on the next cycle and counts as a completed period.
  - Sync-retrigger, period ends with no edge: go to ARMED and pulse_out is held low.
- Active period_div=0: stay in IDLE/ARMED, outputs low. A trigger edge is still consumed.
- Counter: cnt runs 0..period_div-1 in RUN; period_count increments on every wrap or retrigger.
- Channel window: pulse_out[i]=1 exactly in the cycles where busy=1 and delay_i ≤ cnt < delay_i+pw_i.
  - The sum is computed at CW+1 bits, with no wrap-around.
  - The window is truncated at period end; it does not spill into the next period.
  - pw_i=0 or delay_i ≥ period_div: channel stays low.
  - pw_i ≥ period_div with delay_i=0: channel is high for the entire RUN.
- Alignment: pulse_out is registered, computed from next-state cnt, so it is cycle-aligned with cnt and period_start. Latency from trigger-edge sample to cnt=0 is 1 cycle.
- Outputs in IDLE/ARMED: pulse_out=0, period_start=0, busy=0.

Test Plan:
- Free-run phases: load period=8, pw={2,2,2,2}, delay={0,2,4,6}, enable=1 → four non-overlapping 2-cycle pulses per 8-cycle period; period_start every 8 cycles; period_count=3 after 24 RUN cycles.
- Window edge cases: period=10; ch0 delay=8 pw=5; ch1 pw=0; ch2 delay=10; ch3 delay=0 pw=20 → ch0 high at cnt 8–9 only; ch1 and ch2 never high; ch3 constantly high during RUN.
- One-shot: mode=01, period=5, enable=1, trigger edge at cycle t → busy high t+1..t+5, then ARMED. A second edge at t+3 is ignored. A third edge after return to ARMED → one more period.
- Sync-retrigger: mode=10, period=100, trigger edges every 40 cycles → cnt never exceeds 39; period_count increments each edge. Stop triggers → after 100 cycles, ARMED with outputs low.
- Shadow config: free-run period=8; load period=4 at cnt=3 → current period finishes at 8 cycles, following periods are 4. A load coincident with a wrap takes effect one period later.
- Reset mid-run: assert reset at cnt=5 with pulses high → next edge all outputs 0, state IDLE. After release, enable=1 → active config is 0, so no pulses until a new load.
